// File: rtl/fifo_drain_arb.sv
// Round-robin drain arbiter: grants one of N FWFT FIFOs and drains up to BURST
// beats from it into a single registered valid/ready output stage.
module fifo_drain_arb #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_en,
  input  logic [N-1:0]           fifo_empty,
  input  logic [N*WIDTH-1:0]     fifo_data,
  output logic [N-1:0]           fifo_ren,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy
);

  localparam int GW = $clog2(N);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t           state_reg, state_next;
  logic [GW-1:0]    grant_reg, grant_next;
  logic [GW-1:0]    last_grant_reg, last_grant_next;
  logic [CW-1:0]    beat_cnt_reg, beat_cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;

  logic [N-1:0]     eligible;
  logic [WIDTH-1:0] head_data [N];
  logic [GW:0]      rot_sum [N];
  logic [GW-1:0]    rot_idx [N];
  logic [GW-1:0]    sel_idx;
  logic             sel_found;
  logic             pop;
  logic             last_beat;

  assign eligible = req_en & ~fifo_empty;

  // rot_idx[k] is the k-th candidate in priority order, starting after last_grant
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign head_data[gi] = fifo_data[gi*WIDTH +: WIDTH];
      assign fifo_ren[gi]  = pop & (grant_reg == GW'(gi));
      assign rot_sum[gi]   = {1'b0, last_grant_reg} + (GW+1)'(gi + 1);
      assign rot_idx[gi]   = (rot_sum[gi] >= (GW+1)'(N)) ? GW'(rot_sum[gi] - (GW+1)'(N))
                                                         : rot_sum[gi][GW-1:0];
    end
  endgenerate

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = grant_reg;
    for (int k = 0; k < N; k++) begin
      if (!sel_found && eligible[rot_idx[k]]) begin
        sel_found = 1'b1;
        sel_idx   = rot_idx[k];
      end
    end
  end

  // Pop only when the output stage is free or being emptied this cycle; never in reset.
  assign pop = !rst && (state_reg == S_BURST) && eligible[grant_reg]
               && (!out_valid_reg || out_ready);
  assign last_beat = (beat_cnt_reg == CW'(BURST - 1));

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;

    case (state_reg)
      S_IDLE: begin
        if (sel_found) begin
          grant_next    = sel_idx;
          beat_cnt_next = '0;
          state_next    = S_BURST;
        end
      end
      S_BURST: begin
        if (!eligible[grant_reg]) begin
          state_next      = S_IDLE;
          last_grant_next = grant_reg;
        end else if (pop) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (last_beat) begin
            state_next      = S_IDLE;
            last_grant_next = grant_reg;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (pop) begin
      out_valid_next = 1'b1;
      out_data_next  = head_data[grant_reg];
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(N - 1);
      beat_cnt_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign grant_id  = grant_reg;
  assign busy      = (state_reg == S_BURST);

endmodule
